// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources,
// with a registered write stage and a busy scoreboard. Define REGFILE_WB_FWD_EN for write forwarding.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_rd,
`ifdef REGFILE_WB_FWD_EN
  input  logic [ADDR_W-1:0]         fwd_rs1,
  input  logic [ADDR_W-1:0]         fwd_rs2,
  output logic                      fwd1_hit,
  output logic [DATA_W-1:0]         fwd1_data,
  output logic                      fwd2_hit,
  output logic [DATA_W-1:0]         fwd2_data,
`endif
  output logic [(2**ADDR_W)-1:0]    busy_mask,
  output logic [2:0]                grant_id
);

  logic [2:0]              ptr_q, ptr_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       rd_q, rd_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [(2**ADDR_W)-1:0]  busy_q, busy_d;
  logic [NUM_REQ-1:0]      grant_s;
  logic [2:0]              gid_s;
  logic                    any_s;
  logic [3:0]              base_s;
  logic [ADDR_W-1:0]       sel_rd_s;
  logic [DATA_W-1:0]       sel_data_s;

  assign base_s = {1'b0, ptr_q};

  // Round-robin pick: scan distances N..1 from the pointer so the nearest valid requester wins.
  always_comb begin
    grant_s = '0;
    gid_s   = 3'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_s = (req_valid[i] && (((base_s + 4'(k)) == 4'(i)) || ((base_s + 4'(k)) == 4'(i + NUM_REQ))))
                  ? (NUM_REQ'(1'b1) << i) : grant_s;
        gid_s   = (req_valid[i] && (((base_s + 4'(k)) == 4'(i)) || ((base_s + 4'(k)) == 4'(i + NUM_REQ))))
                  ? 3'(i) : gid_s;
      end
    end
  end

  // One-hot AND-OR mux of the winner's destination and data.
  always_comb begin
    sel_rd_s   = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_rd_s   = sel_rd_s   | (grant_s[i] ? req_rd[i*ADDR_W +: ADDR_W]   : {ADDR_W{1'b0}});
      sel_data_s = sel_data_s | (grant_s[i] ? req_data[i*DATA_W +: DATA_W] : {DATA_W{1'b0}});
    end
  end

  // Next state: retiring write clears its busy bit first so a same-edge reservation wins.
  always_comb begin
    any_s   = |grant_s;
    ptr_d   = any_s ? gid_s : ptr_q;
    we_d    = any_s && (sel_rd_s != {ADDR_W{1'b0}});
    rd_d    = any_s ? sel_rd_s : rd_q;
    wdata_d = any_s ? sel_data_s : wdata_q;
    busy_d  = busy_q;
    busy_d[rd_q]   = busy_q[rd_q] & ~we_q;
    busy_d[rsv_rd] = busy_d[rsv_rd] | (rsv_valid & (rsv_rd != {ADDR_W{1'b0}}));
    busy_d[0]      = 1'b0;
  end

  // State registers; pointer resets to the last requester so requester 0 leads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= 3'(NUM_REQ - 1);
      we_q    <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = grant_s;
  assign grant_id  = gid_s;
  assign rf_we     = we_q;
  assign rf_rd     = rd_q;
  assign rf_wdata  = wdata_q;
  assign busy_mask = busy_q;

`ifdef REGFILE_WB_FWD_EN
  assign fwd1_hit  = we_q & (rd_q == fwd_rs1) & (fwd_rs1 != {ADDR_W{1'b0}});
  assign fwd1_data = fwd1_hit ? wdata_q : {DATA_W{1'b0}};
  assign fwd2_hit  = we_q & (rd_q == fwd_rs2) & (fwd_rs2 != {ADDR_W{1'b0}});
  assign fwd2_data = fwd2_hit ? wdata_q : {DATA_W{1'b0}};
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=3, DATA_W=32, ADDR_W=5).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        rsv_valid;
  logic [4:0]  rsv_rd;
  logic [31:0] busy_mask;
  logic [2:0]  grant_id;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0]  fwd_rs1, fwd_rs2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
`endif

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wdata  (rf_wdata),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
`ifdef REGFILE_WB_FWD_EN
    .fwd_rs1   (fwd_rs1),
    .fwd_rs2   (fwd_rs2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
`endif
    .busy_mask (busy_mask),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 3'b000;
    req_rd    = 15'd0;
    req_data  = 96'd0;
    rsv_valid = 1'b0;
    rsv_rd    = 5'd0;
`ifdef REGFILE_WB_FWD_EN
    fwd_rs1   = 5'd0;
    fwd_rs2   = 5'd0;
`endif
    tick();
    tick();
    check_eq("rst_we",    64'(rf_we),     64'd0);
    check_eq("rst_rd",    64'(rf_rd),     64'd0);
    check_eq("rst_wdata", 64'(rf_wdata),  64'd0);
    check_eq("rst_busy",  64'(busy_mask), 64'd0);
    check_eq("rst_ready", 64'(req_ready), 64'd0);
    check_eq("rst_gid",   64'(grant_id),  64'd0);
    reset = 1'b0;

    // Round-robin with all three valid: 0,1,2 then wrap to 0
    req_rd    = {5'd7, 5'd6, 5'd5};
    req_data  = {32'hC0, 32'hB0, 32'hA0};
    req_valid = 3'b111;
    #1;
    check_eq("rr_ready0", 64'(req_ready), 64'b001);
    check_eq("rr_gid0",   64'(grant_id),  64'd0);
    tick();
    check_eq("rr_we0",    64'(rf_we),     64'd1);
    check_eq("rr_rd0",    64'(rf_rd),     64'd5);
    check_eq("rr_data0",  64'(rf_wdata),  64'hA0);
    check_eq("rr_ready1", 64'(req_ready), 64'b010);
    tick();
    check_eq("rr_rd1",    64'(rf_rd),     64'd6);
    check_eq("rr_data1",  64'(rf_wdata),  64'hB0);
    check_eq("rr_ready2", 64'(req_ready), 64'b100);
    check_eq("rr_gid2",   64'(grant_id),  64'd2);
    tick();
    check_eq("rr_we2",    64'(rf_we),     64'd1);
    check_eq("rr_rd2",    64'(rf_rd),     64'd7);
    check_eq("rr_data2",  64'(rf_wdata),  64'hC0);
    check_eq("rr_wrap",   64'(req_ready), 64'b001);
    req_valid = 3'b000;
    #1;
    check_eq("idle_ready", 64'(req_ready), 64'd0);
    tick();
    check_eq("idle_we",   64'(rf_we),     64'd0);
    check_eq("hold_rd",   64'(rf_rd),     64'd7);
    check_eq("hold_data", 64'(rf_wdata),  64'hC0);

    // Lone requester 2
    req_rd    = {5'd3, 5'd0, 5'd0};
    req_data  = {32'h1234, 32'h0, 32'h0};
    req_valid = 3'b100;
    #1;
    check_eq("solo_ready", 64'(req_ready), 64'b100);
    check_eq("solo_gid",   64'(grant_id),  64'd2);
    tick();
    req_valid = 3'b000;
    check_eq("solo_we",   64'(rf_we),    64'd1);
    check_eq("solo_rd",   64'(rf_rd),    64'd3);
    check_eq("solo_data", 64'(rf_wdata), 64'h1234);
    tick();
    check_eq("solo_we_off", 64'(rf_we), 64'd0);

    // Write to x0 is consumed but suppressed
    req_rd    = 15'd0;
    req_data  = {32'h0, 32'h0, 32'hFFFF};
    req_valid = 3'b001;
    #1;
    check_eq("x0_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    check_eq("x0_we",   64'(rf_we),     64'd0);
    check_eq("x0_busy", 64'(busy_mask), 64'd0);

    // Scoreboard reserve, retire, and set-wins-over-clear
    rsv_valid = 1'b1;
    rsv_rd    = 5'd9;
    tick();
    rsv_valid = 1'b0;
    check_eq("rsv9_set", 64'(busy_mask), 64'h200);
    req_rd    = {5'd0, 5'd9, 5'd0};
    req_data  = {32'h0, 32'h99, 32'h0};
    req_valid = 3'b010;
    #1;
    check_eq("w9_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    check_eq("w9_we",      64'(rf_we),     64'd1);
    check_eq("w9_busy_pre", 64'(busy_mask), 64'h200);
    tick();
    check_eq("w9_retired", 64'(busy_mask), 64'd0);
    rsv_valid = 1'b1;
    tick();
    rsv_valid = 1'b0;
    req_valid = 3'b010;
    #1;
    check_eq("w9b_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = 3'b000;
    check_eq("w9b_we", 64'(rf_we), 64'd1);
    rsv_valid = 1'b1;
    tick();
    check_eq("set_wins", 64'(busy_mask), 64'h200);
    rsv_rd = 5'd0;
    tick();
    rsv_valid = 1'b0;
    check_eq("rsv_x0", 64'(busy_mask), 64'h200);

    // Reset mid-operation with a pending write and busy bits 4 and 9
    req_rd    = {5'd0, 5'd0, 5'd4};
    req_data  = {32'h0, 32'h0, 32'h55};
    req_valid = 3'b001;
    rsv_valid = 1'b1;
    rsv_rd    = 5'd4;
    #1;
    check_eq("w4_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = 3'b000;
    rsv_valid = 1'b0;
    check_eq("w4_we",   64'(rf_we),     64'd1);
    check_eq("w4_rd",   64'(rf_rd),     64'd4);
    check_eq("w4_busy", 64'(busy_mask), 64'h210);
`ifdef REGFILE_WB_FWD_EN
    fwd_rs1 = 5'd4;
    fwd_rs2 = 5'd0;
    #1;
    check_eq("fwd1_hit",  64'(fwd1_hit),  64'd1);
    check_eq("fwd1_data", 64'(fwd1_data), 64'h55);
    check_eq("fwd2_hit",  64'(fwd2_hit),  64'd0);
    check_eq("fwd2_data", 64'(fwd2_data), 64'd0);
`endif
    reset = 1'b1;
    #1;
    check_eq("mid_rst_we",   64'(rf_we),     64'd0);
    check_eq("mid_rst_busy", 64'(busy_mask), 64'd0);
    tick();
    reset     = 1'b0;
    req_rd    = {5'd7, 5'd6, 5'd5};
    req_data  = {32'hC0, 32'hB0, 32'hA0};
    req_valid = 3'b111;
    #1;
    check_eq("post_rst_ready", 64'(req_ready), 64'b001);
    check_eq("post_rst_gid",   64'(grant_id),  64'd0);
    tick();
    req_valid = 3'b000;
    check_eq("post_rst_rd", 64'(rf_rd), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between NUM_REQ writeback requesters (ALU, load unit, multiplier, ...) using round-robin arbitration with valid/ready handshakes. It registers the winning write into an output stage that drives the register file's write-enable, destination-address and write-data inputs, with one cycle of latency. It also keeps a 32-entry busy scoreboard: the issue stage reserves a destination register, and the retiring write releases it, so hazard logic can stall on pending registers.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register address width; scoreboard depth is 2**ADDR_W

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
req_valid  input  NUM_REQ  per-requester write request
req_rd  input  NUM_REQ*ADDR_W  packed destination registers; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
rf_we  output  1  register file write enable (registered)
rf_rd  output  ADDR_W  register file destination (registered)
rf_wdata  output  DATA_W  register file write data (registered)
rsv_valid  input  1  issue stage reserves register rsv_rd
rsv_rd  input  ADDR_W  register to mark busy
busy_mask  output  2**ADDR_W  bit n = write to register n outstanding (registered)
grant_id  output  3  index of the requester granted this cycle; 0 when none

Behaviour:
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, busy_mask=0, grant pointer=NUM_REQ-1, so requester 0 has top priority after reset.
- Arbitration is combinational from req_valid and the pointer. The search starts at pointer+1 mod NUM_REQ; the first valid requester found wins.
- req_ready is one-hot on the winner and all-zero when no request is valid. req_ready never depends on the requester's data.
- The output stage accepts every cycle, so at most one transfer occurs per cycle. Requesters hold valid, rd and data stable until ready is seen.
- On a transfer from requester g at edge T:
  - pointer <= g.
  - rf_rd and rf_wdata <= requester g's rd and data.
  - rf_we <= 1 if that rd != 0.
  - The write is visible on the rf_* outputs during cycle T+1, and the register file commits it at edge T+1.
- No transfer at edge T: rf_we <= 0. rf_rd and rf_wdata hold their previous values.
- rd == 0: the request is still granted and consumed, but rf_we stays 0 (x0 writes suppressed) and busy_mask is unaffected.
- Pointer wrap: a grant to NUM_REQ-1 makes requester 0 the next highest priority.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,..,NUM_REQ-1,0,... A requester waits at most NUM_REQ-1 cycles.
- Scoreboard updates at each edge:
  - Set bit rsv_rd if rsv_valid and rsv_rd != 0.
  - Clear bit rf_rd if rf_we is currently 1 (the write retiring at this edge).
  - Set and clear of the same register on the same edge: set wins (a new reservation supersedes the retiring write).
  - busy_mask bit 0 is always 0.
- Reset asserted mid-operation: any registered write is discarded (rf_we drops immediately) and all busy bits clear.
- req_valid deasserted without a grant is legal; no state changes.

Optional Feature:
REGFILE_WB_FWD_EN
- Defined: adds ports fwd_rs1 (in, ADDR_W), fwd_rs2 (in, ADDR_W), fwd1_hit (out, 1), fwd1_data (out, DATA_W), fwd2_hit (out, 1), fwd2_data (out, DATA_W).
  - fwdN_hit = rf_we & (rf_rd == fwd_rsN) & (fwd_rsN != 0).
  - fwdN_data = rf_wdata when hit, 0 otherwise. Purely combinational.
  - Lets readers see the write in the same cycle the register file commits it.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then req_valid=3'b111 held with rd=5/6/7 and data 0xA0/0xB0/0xC0 -> req_ready sequence 001,010,100,001. rf_we=1 one cycle after each grant, with rf_rd=5,6,7 and rf_wdata=0xA0,0xB0,0xC0.
- Only requester 2 valid (rd=3, data=0x1234) for one cycle -> req_ready=100 and grant_id=2 that cycle. Next cycle rf_we=1, rf_rd=3, rf_wdata=0x1234. The following cycle rf_we=0.
- Requester 0 valid with rd=0, data=0xFFFF -> req_ready[0]=1, rf_we stays 0, busy_mask unchanged.
- rsv_valid with rsv_rd=9 -> busy_mask[9]=1 next cycle. A later write to rd=9 clears bit 9 at the edge ending rf_we=1. A reservation of 9 on that same edge keeps bit 9 set.
- Assert reset while rf_we=1 and busy_mask=0x0000_0210 -> rf_we=0 and busy_mask=0 immediately. After release, requester 0 wins first.
- With REGFILE_WB_FWD_EN defined: rf_we=1, rf_rd=4, rf_wdata=0x55 and fwd_rs1=4, fwd_rs2=0 -> fwd1_hit=1, fwd1_data=0x55, fwd2_hit=0, fwd2_data=0.
